// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the single-I/O SPI SRAM master.
package spi_ram_pkg;

  localparam logic [7:0] OpRead     = 8'h03;
  localparam logic [7:0] OpFastRead = 8'h0B;
  localparam logic [7:0] OpWrite    = 8'h02;

  typedef enum logic [2:0] {
    MdRead     = 3'd0,
    MdFastRead = 3'd1
  } spi_md_e;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
    StDone
  } spi_master_state_e;

  typedef struct packed {
    logic [4:0] hi;
    logic [4:0] lo;
  } spi_div_t;

  // Data words travel least-significant byte first on the wire.
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [4:0] div_fix(input logic [4:0] v);
    return (v == 5'd0) ? 5'd1 : v;
  endfunction

endpackage

// File: rtl/spi_ram_sclk_gen.sv
// SCLK phase generator: low for lo cycles, then high for hi cycles, while enabled.
module spi_ram_sclk_gen (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [4:0] hi_i,
  input  logic [4:0] lo_i,
  output logic       sclk_o,
  output logic       rise_o,
  output logic       fall_o
);

  logic [4:0] cnt_q;

  // Strobes mark the clk_i edge on which sclk_o is about to toggle.
  assign rise_o = en_i & ~sclk_o & (cnt_q == lo_i - 5'd1);
  assign fall_o = en_i &  sclk_o & (cnt_q == hi_i - 5'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 5'd0;
      sclk_o <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= 5'd0;
      sclk_o <= 1'b0;
    end else if (rise_o || fall_o) begin
      cnt_q  <= 5'd0;
      sclk_o <= ~sclk_o;
    end else begin
      cnt_q  <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/spi_ram_master.sv
// Framed SPI mode-0 transaction engine for a single-I/O serial SRAM.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned CsIdleCycles = 2,
  parameter int unsigned AddrBytes    = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // 4-phase handshake: req_i rises and stays high until rsp_o is seen; rsp_o
  // then stays high (rdata_o valid) until req_i falls. Dropping req_i before
  // rsp_o aborts the frame and no response is given.
  input  logic        req_i,
  input  logic        we_i,
  input  logic        cfg_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  md_i,
  output logic        rsp_o,
  output logic [31:0] rdata_o,
  input  logic        clk_cfg_i,
  input  logic [4:0]  clk_div_hi_i,
  input  logic [4:0]  clk_div_lo_i,
  output logic        busy_o,
  output logic        spi_sclk_o,
  output logic        spi_cs_no,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i
);

  localparam int unsigned AddrW   = 8 * AddrBytes;
  localparam int unsigned TxW     = 48 + AddrW;
  localparam logic [6:0]  LenRw   = 7'(40 + AddrW);
  localparam logic [6:0]  LenFast = 7'(48 + AddrW);
  localparam logic [6:0]  LenCfg  = 7'd16;
  localparam logic [3:0]  HoldEnd = 4'(CsIdleCycles - 1);

  spi_master_state_e state_q;
  spi_div_t          div_q, act_q, div_new, div_eff;
  logic [TxW-1:0]    tx_q, frame_d;
  logic [31:0]       rx_q;
  logic [6:0]        bit_q, len_q, dstart_q, len_d, dstart_d;
  logic [3:0]        hold_q;
  logic              is_read_q, read_d, aborted_q, fast;
  logic              sclk_raw, sck_rise, sck_fall, gen_en;
  logic              unused_addr;

  assign unused_addr = ^addr_i;
  assign div_new = '{hi: div_fix(clk_div_hi_i), lo: div_fix(clk_div_lo_i)};
  assign div_eff = clk_cfg_i ? div_new : div_q;
  assign fast    = (md_i == MdFastRead);

  always_comb begin
    frame_d  = '0;
    len_d    = LenRw;
    dstart_d = 7'(8 + AddrW);
    read_d   = 1'b0;
    if (cfg_i) begin
      frame_d[TxW-1 -: 16] = {addr_i[7:0], wdata_i[7:0]};
      len_d = LenCfg;
    end else if (we_i) begin
      frame_d[TxW-1 -: 8]            = OpWrite;
      frame_d[TxW-9 -: AddrW]        = addr_i[AddrW-1:0];
      frame_d[TxW-9-AddrW -: 32]     = byte_swap(wdata_i);
    end else begin
      frame_d[TxW-1 -: 8]            = fast ? OpFastRead : OpRead;
      frame_d[TxW-9 -: AddrW]        = addr_i[AddrW-1:0];
      len_d    = fast ? LenFast : LenRw;
      dstart_d = fast ? 7'(16 + AddrW) : 7'(8 + AddrW);
      read_d   = 1'b1;
    end
  end

  // The generator is stopped on the same edge that sees an abort.
  assign gen_en = (state_q == StShift) && req_i;

  spi_ram_sclk_gen u_sclk_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (gen_en),
    .hi_i   (act_q.hi),
    .lo_i   (act_q.lo),
    .sclk_o (sclk_raw),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  assign spi_sclk_o = sclk_raw & req_i;
  assign busy_o     = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      div_q     <= '{hi: 5'd1, lo: 5'd1};
      act_q     <= '{hi: 5'd1, lo: 5'd1};
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
      len_q     <= '0;
      dstart_q  <= '0;
      hold_q    <= '0;
      is_read_q <= 1'b0;
      aborted_q <= 1'b0;
      spi_cs_no <= 1'b1;
      spi_sdo_o <= 1'b0;
      rsp_o     <= 1'b0;
      rdata_o   <= '0;
    end else begin
      if (clk_cfg_i) div_q <= div_new;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            act_q     <= div_eff;
            tx_q      <= frame_d;
            spi_sdo_o <= frame_d[TxW-1];
            len_q     <= len_d;
            dstart_q  <= dstart_d;
            is_read_q <= read_d;
            rx_q      <= '0;
            bit_q     <= '0;
            aborted_q <= 1'b0;
            spi_cs_no <= 1'b0;
            state_q   <= StCsSetup;
          end
        end
        StCsSetup, StShift: begin
          if (!req_i) begin
            aborted_q <= 1'b1;
            spi_cs_no <= 1'b1;
            spi_sdo_o <= 1'b0;
            hold_q    <= '0;
            state_q   <= StCsHold;
          end else if (state_q == StCsSetup) begin
            state_q <= StShift;
          end else begin
            if (sck_rise && is_read_q && (bit_q >= dstart_q))
              rx_q <= {rx_q[30:0], spi_sdi_i};
            if (sck_fall) begin
              if (bit_q == len_q - 7'd1) begin
                spi_cs_no <= 1'b1;
                spi_sdo_o <= 1'b0;
                hold_q    <= '0;
                state_q   <= StCsHold;
              end else begin
                bit_q     <= bit_q + 7'd1;
                tx_q      <= tx_q << 1;
                spi_sdo_o <= tx_q[TxW-2];
              end
            end
          end
        end
        StCsHold: begin
          if (!req_i) aborted_q <= 1'b1;
          if (hold_q == HoldEnd) begin
            if (aborted_q || !req_i) begin
              state_q <= StIdle;
            end else begin
              rsp_o   <= 1'b1;
              rdata_o <= is_read_q ? byte_swap(rx_q) : '0;
              state_q <= StDone;
            end
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        StDone: begin
          if (!req_i) begin
            rsp_o   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench: an SPI slave/monitor plus a byte-level frame model.
module tb_spi_ram_master;

  localparam int AddrBytes = 3;
  localparam int CsIdle    = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, cfg_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [2:0]  md_i = '0;
  logic        rsp_o;
  logic [31:0] rdata_o;
  logic        clk_cfg_i = 1'b0;
  logic [4:0]  clk_div_hi_i = '0, clk_div_lo_i = '0;
  logic        busy_o, spi_sclk_o, spi_cs_no, spi_sdo_o;
  logic        spi_sdi_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  spi_ram_master #(.CsIdleCycles(CsIdle), .AddrBytes(AddrBytes)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .cfg_i(cfg_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .md_i(md_i), .rsp_o(rsp_o), .rdata_o(rdata_o),
    .clk_cfg_i(clk_cfg_i), .clk_div_hi_i(clk_div_hi_i), .clk_div_lo_i(clk_div_lo_i),
    .busy_o(busy_o), .spi_sclk_o(spi_sclk_o), .spi_cs_no(spi_cs_no),
    .spi_sdo_o(spi_sdo_o), .spi_sdi_i(spi_sdi_i)
  );

  // Monitor and slave state
  int   pulses, cs_low, hi_run, lo_run;
  logic prev_sclk = 1'b0;
  int   hi_runs[$], lo_runs[$];
  logic mosi_q[$];
  logic miso_bits[0:127];

  // Expected frame (model)
  logic        exp_q[$];
  logic [31:0] exp_rdata;
  int          exp_len;
  bit          exp_is_read;
  int          cur_hi = 1, cur_lo = 1;

  always @(negedge clk_i) begin
    if (!spi_cs_no) cs_low++;
    if (spi_sclk_o) begin
      if (!prev_sclk) begin
        pulses++;
        mosi_q.push_back(spi_sdo_o);
        if (pulses > 1) lo_runs.push_back(lo_run);
        hi_run = 0;
      end
      hi_run++;
    end else begin
      if (prev_sclk) begin
        hi_runs.push_back(hi_run);
        lo_run = 0;
      end
      lo_run++;
    end
    prev_sclk = spi_sclk_o;
    spi_sdi_i = miso_bits[pulses];
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic mon_clear();
    pulses = 0; cs_low = 0; hi_run = 0; lo_run = 0;
    hi_runs.delete(); lo_runs.delete(); mosi_q.delete();
  endtask

  task automatic set_div(input int hi, input int lo);
    tick();
    clk_cfg_i = 1'b1; clk_div_hi_i = 5'(hi); clk_div_lo_i = 5'(lo);
    tick();
    clk_cfg_i = 1'b0;
    cur_hi = (hi == 0) ? 1 : hi;
    cur_lo = (lo == 0) ? 1 : lo;
  endtask

  task automatic build_expect(input logic we, input logic cfg, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] md,
                              input logic [31:0] resp);
    logic [7:0] b[$];
    bit fast;
    int ds;
    exp_q.delete();
    fast = (md == 3'd1);
    exp_is_read = !cfg && !we;
    if (cfg) begin
      b.push_back(addr[7:0]);
      b.push_back(wdata[7:0]);
      exp_len = 16;
    end else begin
      b.push_back(we ? 8'h02 : (fast ? 8'h0B : 8'h03));
      for (int i = AddrBytes - 1; i >= 0; i--) b.push_back(addr[8*i +: 8]);
      if (we) for (int i = 0; i < 4; i++) b.push_back(wdata[8*i +: 8]);
      else if (fast) b.push_back(8'h00);
      exp_len = 8 + 8 * AddrBytes + ((fast && !we) ? 8 : 0) + 32;
    end
    foreach (b[i]) for (int k = 7; k >= 0; k--) exp_q.push_back(b[i][k]);
    // Slave drives random junk everywhere; the reply bytes sit after the header.
    for (int i = 0; i < 128; i++) miso_bits[i] = 1'($urandom_range(0, 1));
    exp_rdata = '0;
    if (exp_is_read) begin
      ds = exp_len - 32;
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 8; k++) miso_bits[ds + 8*j + (7-k)] = resp[8*j + k];
      exp_rdata = resp;
    end
  endtask

  task automatic drive_req(input logic we, input logic cfg, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] md);
    we_i = we; cfg_i = cfg; addr_i = addr; wdata_i = wdata; md_i = md;
    req_i = 1'b1;
  endtask

  task automatic run_txn(input string name, input logic we, input logic cfg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] md, input logic [31:0] resp,
                         input bit load_div, input int new_hi, input int new_lo,
                         input int mid_cfg_at);
    int cnt, budget, hi, lo, exp_lat;
    bit cfg_done, ok;
    build_expect(we, cfg, addr, wdata, md, resp);
    mon_clear();
    if (load_div) begin
      clk_cfg_i = 1'b1; clk_div_hi_i = 5'(new_hi); clk_div_lo_i = 5'(new_lo);
      cur_hi = (new_hi == 0) ? 1 : new_hi;
      cur_lo = (new_lo == 0) ? 1 : new_lo;
    end
    hi = cur_hi; lo = cur_lo;
    drive_req(we, cfg, addr, wdata, md);
    budget = exp_len * (hi + lo) + 40;
    cnt = 0; cfg_done = 0;
    while (rsp_o !== 1'b1 && cnt < budget) begin
      tick(); cnt++;
      clk_cfg_i = 1'b0;
      if (mid_cfg_at > 0 && !cfg_done && pulses >= mid_cfg_at) begin
        clk_cfg_i = 1'b1; clk_div_hi_i = 5'd0; clk_div_lo_i = 5'd0;
        cfg_done = 1;
      end
    end
    clk_cfg_i = 1'b0;
    if (mid_cfg_at > 0) begin cur_hi = 1; cur_lo = 1; end

    exp_lat = 2 + exp_len * (hi + lo) + CsIdle;
    n_cmp++;
    if (cnt !== exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d cycles, expected %0d", name, cnt, exp_lat);
    end
    n_cmp++;
    if (pulses !== exp_len) begin
      n_err++; $display("FAIL %s sclk_pulses: got %0d, expected %0d", name, pulses, exp_len);
    end
    n_cmp++;
    if (cs_low !== 1 + exp_len * (hi + lo)) begin
      n_err++; $display("FAIL %s cs_low_cycles: got %0d, expected %0d", name, cs_low, 1 + exp_len * (hi + lo));
    end
    ok = (mosi_q.size() >= exp_q.size());
    if (ok) foreach (exp_q[i]) if (mosi_q[i] !== exp_q[i]) ok = 0;
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL %s mosi_bits: got %0d bits, expected pattern of %0d bits differs", name, mosi_q.size(), exp_q.size());
    end
    ok = (hi_runs.size() == exp_len) && (lo_runs.size() == exp_len - 1);
    foreach (hi_runs[i]) if (hi_runs[i] != hi) ok = 0;
    foreach (lo_runs[i]) if (lo_runs[i] != lo) ok = 0;
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL %s sclk_timing: got first high %0d / %0d runs, expected hi %0d lo %0d", name,
                        (hi_runs.size() > 0) ? hi_runs[0] : -1, hi_runs.size(), hi, lo);
    end
    if (!we || cfg) begin
      n_cmp++;
      if (rdata_o !== exp_rdata) begin
        n_err++; $display("FAIL %s rdata: got %08h, expected %08h", name, rdata_o, exp_rdata);
      end
    end
    req_i = 1'b0;
    tick();
    n_cmp++;
    if (rsp_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL %s release: got rsp=%b busy=%b, expected 0 0", name, rsp_o, busy_o);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 128; i++) miso_bits[i] = 1'b0;
    rst_ni = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({spi_cs_no, spi_sclk_o, spi_sdo_o, rsp_o, busy_o} !== 5'b10000) begin
      n_err++; $display("FAIL reset_outputs: got cs_n/sclk/sdo/rsp/busy=%b, expected 10000",
                        {spi_cs_no, spi_sclk_o, spi_sdo_o, rsp_o, busy_o});
    end
    n_cmp++;
    if (rdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %08h, expected 00000000", rdata_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_write();
    run_txn("write_plan", 1'b1, 1'b0, 32'h0000_0123, 32'hA1B2_C3D4, 3'd0, 32'h0, 0, 0, 0, 0);
    run_txn("write_rand", 1'b1, 1'b0, $urandom, $urandom, 3'(($urandom_range(0, 7))), 32'h0, 0, 0, 0, 0);
  endtask

  task automatic test_read();
    run_txn("read_plan", 1'b0, 1'b0, $urandom, 32'h0, 3'd0, 32'h4433_2211, 0, 0, 0, 0);
    run_txn("read_md5", 1'b0, 1'b0, $urandom, $urandom, 3'd5, $urandom, 0, 0, 0, 0);
  endtask

  task automatic test_fast_read();
    set_div(2, 3);
    run_txn("fast_read", 1'b0, 1'b0, $urandom, 32'h0, 3'd1, $urandom, 0, 0, 0, 0);
    run_txn("fast_read_cfg_with_req", 1'b0, 1'b0, $urandom, 32'h0, 3'd1, $urandom, 1, 4, 1, 0);
  endtask

  task automatic test_cfg();
    set_div(1, 1);
    run_txn("cfg_frame", 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0040, 3'd1, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    logic [31:0] rd_before;
    int cnt;
    set_div(1, 1);
    rd_before = rdata_o;
    build_expect(1'b0, 1'b0, $urandom, 32'h0, 3'd0, $urandom);
    mon_clear();
    drive_req(1'b0, 1'b0, addr_i, 32'h0, 3'd0);
    cnt = 0;
    while (pulses < 20 && cnt < 200) begin tick(); cnt++; end
    req_i = 1'b0;
    #1;
    n_cmp++;
    if (spi_sclk_o !== 1'b0 || cnt >= 200) begin
      n_err++; $display("FAIL abort_sclk: got sclk=%b after %0d cycles, expected 0", spi_sclk_o, cnt);
    end
    tick();
    tick();
    n_cmp++;
    if ({busy_o, spi_cs_no, rsp_o} !== 3'b110) begin
      n_err++; $display("FAIL abort_hold: got busy/cs_n/rsp=%b, expected 110", {busy_o, spi_cs_no, rsp_o});
    end
    tick();
    n_cmp++;
    if ({busy_o, spi_cs_no, rsp_o} !== 3'b010 || rdata_o !== rd_before) begin
      n_err++; $display("FAIL abort_idle: got busy/cs_n/rsp=%b rdata=%08h, expected 010 rdata=%08h",
                        {busy_o, spi_cs_no, rsp_o}, rdata_o, rd_before);
    end
    // Abort while chip select is already in its idle period.
    build_expect(1'b1, 1'b0, $urandom, $urandom, 3'd0, 32'h0);
    mon_clear();
    drive_req(1'b1, 1'b0, addr_i, wdata_i, 3'd0);
    cnt = 0;
    while (!(spi_cs_no === 1'b1 && pulses == exp_len) && cnt < 300) begin tick(); cnt++; end
    req_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy_o, rsp_o} !== 2'b00 || cnt >= 300) begin
      n_err++; $display("FAIL abort_in_hold: got busy/rsp=%b after %0d cycles, expected 00", {busy_o, rsp_o}, cnt);
    end
    run_txn("after_abort", 1'b0, 1'b0, $urandom, 32'h0, 3'd0, $urandom, 0, 0, 0, 0);
  endtask

  task automatic test_div_midframe();
    set_div(2, 3);
    run_txn("div_midframe_old", 1'b1, 1'b0, $urandom, $urandom, 3'd0, 32'h0, 0, 0, 0, 5);
    run_txn("div_midframe_new", 1'b0, 1'b0, $urandom, 32'h0, 3'd0, $urandom, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midframe();
    int cnt;
    set_div(3, 2);
    build_expect(1'b1, 1'b0, $urandom, $urandom, 3'd0, 32'h0);
    mon_clear();
    drive_req(1'b1, 1'b0, addr_i, wdata_i, 3'd0);
    cnt = 0;
    while (pulses < 10 && cnt < 300) begin tick(); cnt++; end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({spi_cs_no, spi_sclk_o, spi_sdo_o, rsp_o, busy_o} !== 5'b10000 || cnt >= 300) begin
      n_err++; $display("FAIL reset_midframe: got cs_n/sclk/sdo/rsp/busy=%b, expected 10000",
                        {spi_cs_no, spi_sclk_o, spi_sdo_o, rsp_o, busy_o});
    end
    req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    cur_hi = 1; cur_lo = 1;
    tick();
    run_txn("after_reset", 1'b0, 1'b0, $urandom, 32'h0, 3'd0, $urandom, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic we, cfg;
    bit ld;
    for (int i = 0; i < 12; i++) begin
      we  = 1'($urandom_range(0, 1));
      cfg = ($urandom_range(0, 3) == 0);
      ld  = ($urandom_range(0, 2) == 0);
      run_txn($sformatf("b2b_%0d", i), we, cfg, $urandom, $urandom, 3'($urandom_range(0, 7)),
              $urandom, ld, $urandom_range(0, 4), $urandom_range(0, 4), 0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fast_read();
    test_cfg();
    test_abort();
    test_div_midframe();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
